// File: rtl/dot_product_engine_if.sv
// dot_product_engine_if: start/result handshake and memory read port of dot_product_engine
interface dot_product_engine_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int ACC_WIDTH  = 19
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] a_base;
    logic [ADDR_WIDTH-1:0] b_base;
    logic                  busy;
    logic                  done;
    logic [ACC_WIDTH-1:0]  result;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    modport master (
        output start, a_base, b_base, mem_rd_data,
        input  busy, done, result, mem_rd_en, mem_rd_addr
    );
    modport slave (
        input  start, a_base, b_base, mem_rd_data,
        output busy, done, result, mem_rd_en, mem_rd_addr
    );
endinterface

// File: rtl/dot_product_engine.sv
// dot_product_engine: streams interleaved A/B vectors from a registered-read memory and MACs their dot product
module dot_product_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int VEC_LEN    = 8,
    parameter int CNT_WIDTH  = 5,
    parameter int ACC_WIDTH  = 19
) (
    input logic clk,
    input logic rst,
    dot_product_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   a_base_q, a_base_d, b_base_q, b_base_d, addr_q, addr_d;
    logic                    rd_en_q, rd_en_d, rd_b_q, rd_b_d, vld_q, vld_d, ret_b_q, ret_b_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   a_lat_q, a_lat_d;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d, result_q, result_d;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [ADDR_WIDTH-1:0]   off;
    assign prod = a_lat_q * bus.mem_rd_data;
    assign off  = ADDR_WIDTH'(cnt_q >> 1);
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_base_d = a_base_q;
        b_base_d = b_base_q;
        addr_d   = addr_q;
        rd_en_d  = 1'b0;
        rd_b_d   = 1'b0;
        vld_d    = rd_en_q;
        ret_b_d  = rd_b_q;
        a_lat_d  = a_lat_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = 1'b0;
        // returning data is tagged with the kind of issue it answers, one cycle behind
        if (vld_q) begin
            if (ret_b_q) acc_d = acc_q + ACC_WIDTH'(prod);
            else a_lat_d = bus.mem_rd_data;
        end
        case (state_q)
            IDLE: if (bus.start) begin
                state_d  = ISSUE;
                a_base_d = bus.a_base;
                b_base_d = bus.b_base;
                acc_d    = '0;
                cnt_d    = CNT_WIDTH'(1);
                rd_en_d  = 1'b1;
                addr_d   = bus.a_base;
            end
            ISSUE: if (cnt_q == CNT_WIDTH'(2*VEC_LEN)) begin
                state_d = DRAIN;
            end else begin
                rd_en_d = 1'b1;
                rd_b_d  = cnt_q[0];
                addr_d  = (cnt_q[0] ? b_base_q : a_base_q) + off;
                cnt_d   = cnt_q + 1'b1;
            end
            DRAIN: begin
                state_d  = DONE;
                result_d = acc_d;
                done_d   = 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            addr_q   <= '0;
            rd_en_q  <= 1'b0;
            rd_b_q   <= 1'b0;
            vld_q    <= 1'b0;
            ret_b_q  <= 1'b0;
            a_lat_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_base_q <= a_base_d;
            b_base_q <= b_base_d;
            addr_q   <= addr_d;
            rd_en_q  <= rd_en_d;
            rd_b_q   <= rd_b_d;
            vld_q    <= vld_d;
            ret_b_q  <= ret_b_d;
            a_lat_q  <= a_lat_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end
    assign bus.busy        = state_q != IDLE;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_rd_addr = addr_q;
endmodule

// File: tb/tb_dot_product_engine.sv
// tb_dot_product_engine: directed vector table plus reset and back-to-back sequences
module tb_dot_product_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] mem [32];
    int total = 0;
    int bad = 0;
    dot_product_engine_if ia ();
    dot_product_engine dut (.clk(clk), .rst(rst), .bus(ia));
    always #5 clk = ~clk;
    always @(posedge clk) if (ia.mem_rd_en) ia.mem_rd_data <= mem[ia.mem_rd_addr];
    typedef struct {
        int         fill;
        logic [4:0] a;
        logic [4:0] b;
        logic [18:0] exp;
        int         pulse;
    } vec_t;
    vec_t tbl [7];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask
    task automatic fill_mem(input int mode);
        for (int i = 0; i < 32; i++)
            mem[i] = mode == 1 ? 8'hFF : (mode == 2 && i < 8) ? 8'h00 : 8'(i + 160);
    endtask
    task automatic run_op(input logic [4:0] a, input logic [4:0] b, input logic [18:0] exp, input int pulse);
        int n = 0;
        int nd = 0;
        int dcyc = -1;
        int bad_addr = 0;
        logic [4:0] want;
        @(negedge clk);
        ia.start = 1'b1;
        ia.a_base = a;
        ia.b_base = b;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            ia.start = 1'b0;
            if (k == 1) begin
                ia.a_base = ~a;
                ia.b_base = ~b;
            end
            if (ia.mem_rd_en) begin
                want = n[0] ? b + 5'(n / 2) : a + 5'(n / 2);
                if (ia.mem_rd_addr !== want) bad_addr++;
                n++;
            end
            if (ia.done) begin
                nd++;
                dcyc = k;
                chk("result", 32'(ia.result), 32'(exp));
                chk("busy_in_done", 32'(ia.busy), 32'd1);
            end
            if (pulse != 0 && (k == 5 || k == 18)) ia.start = 1'b1;
        end
        chk("addr_seq", bad_addr, 0);
        chk("issue_count", n, 16);
        chk("done_cycle", dcyc, 18);
        chk("done_pulses", nd, 1);
        chk("busy_idle", 32'(ia.busy), 32'd0);
        chk("result_held", 32'(ia.result), 32'(exp));
    endtask
    initial begin
        int d1;
        int d2;
        int k;
        tbl[0] = '{0, 5'd0,  5'd8,  19'h36C6C, 0};
        tbl[1] = '{1, 5'd0,  5'd8,  19'h7F008, 0};
        tbl[2] = '{0, 5'd28, 5'd0,  19'h37FDC, 0};
        tbl[3] = '{0, 5'd0,  5'd8,  19'h36C6C, 1};
        tbl[4] = '{2, 5'd0,  5'd8,  19'h00000, 0};
        tbl[5] = '{0, 5'd0,  5'd0,  19'h3438C, 0};
        tbl[6] = '{0, 5'd24, 5'd16, 19'h41BEC, 0};
        ia.start = 1'b0;
        ia.a_base = '0;
        ia.b_base = '0;
        fill_mem(0);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(ia.busy), 32'd0);
        chk("rst_done", 32'(ia.done), 32'd0);
        chk("rst_result", 32'(ia.result), 32'd0);
        chk("rst_rd_en", 32'(ia.mem_rd_en), 32'd0);
        chk("rst_rd_addr", 32'(ia.mem_rd_addr), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            fill_mem(tbl[i].fill);
            run_op(tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].pulse);
        end
        fill_mem(0);
        // abort mid-ISSUE, then rerun from clean state
        @(negedge clk);
        ia.start = 1'b1;
        ia.a_base = 5'd0;
        ia.b_base = 5'd8;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            ia.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(ia.busy), 32'd0);
        chk("abort_rd_en", 32'(ia.mem_rd_en), 32'd0);
        chk("abort_result", 32'(ia.result), 32'd0);
        chk("abort_done", 32'(ia.done), 32'd0);
        rst = 1'b0;
        run_op(5'd0, 5'd8, 19'h36C6C, 0);
        // start held high: second accept in the first IDLE cycle after DONE
        d1 = -1;
        d2 = -1;
        k = 0;
        @(negedge clk);
        ia.start = 1'b1;
        ia.a_base = 5'd0;
        ia.b_base = 5'd8;
        repeat (45) begin
            @(negedge clk);
            k++;
            if (k == 20) ia.start = 1'b0;
            if (ia.done) begin
                chk("b2b_result", 32'(ia.result), 32'h36C6C);
                if (d1 < 0) d1 = k;
                else d2 = k;
            end
        end
        chk("b2b_first", d1, 18);
        chk("b2b_second", d2, 37);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
